uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter sharing one `uart_tx` transmitter between `NUM_REQ` byte sources. It accepts bytes from requesters over a valid/ack handshake and issues each byte to the transmitter as a single-cycle `i_Tx_DV` pulse. It then holds off the next grant until the transmitter has finished the frame and returned to idle. It sits between the debug/status producers and `uart_tx`, which is instantiated unmodified next to it.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `PTR_W`, `$clog2(NUM_REQ)`: width of the round-robin pointer. Derived; do not override.

Ports:
- `i_Clock`  in  1  system clock; all logic is on the rising edge.
- `i_Rst_L`  in  1  asynchronous, active-low reset.
- `i_Req_DV`  in  NUM_REQ  per-requester byte valid; held until the matching ack.
- `i_Req_Byte`  in  8*NUM_REQ  byte for requester k at bits [8k+7:8k].
- `o_Req_Ack`  out  NUM_REQ  one-cycle pulse; the requester's byte has been captured.
- `o_Grant`  out  NUM_REQ  one-hot; the requester whose byte is in flight.
- `o_Busy`  out  1  high in every state except IDLE.
- `o_Tx_DV`  out  1  to `uart_tx` `i_Tx_DV`; single-cycle pulse.
- `o_Tx_Byte`  out  8  to `uart_tx` `i_Tx_Byte`.
- `i_Tx_Active`  in  1  from `uart_tx` `o_Tx_Active`.
- `i_Tx_Done`  in  1  from `uart_tx` `o_Tx_Done`; high for 2 cycles per frame.

## Operation
- All outputs are registered.
- Reset values: `o_Req_Ack`=0, `o_Grant`=0, `o_Busy`=1 (state is SYNC), `o_Tx_DV`=0, `o_Tx_Byte`=8'h00. The round-robin pointer resets to 0.
- States:
  - SYNC: the reset state. Exit to IDLE when `i_Tx_Active`=0 and `i_Tx_Done`=0. The transmitter has no reset, so this drains any frame left in flight.
  - IDLE: if any `i_Req_DV` bit is set, select the winner k. Search starts at the pointer and increments modulo NUM_REQ, wrapping from NUM_REQ-1 to 0.
    - On selection: capture the byte into `o_Tx_Byte`, set `o_Grant[k]`, pulse `o_Req_Ack[k]`, pulse `o_Tx_DV`, and go to ISSUE.
    - If no `i_Req_DV` bit is set: stay in IDLE and leave the outputs unchanged.
  - ISSUE: clear `o_Tx_DV` and `o_Req_Ack`, then go to WAIT_DONE. This state lasts exactly one cycle.
  - WAIT_DONE: wait for `i_Tx_Done`=1, then go to RELEASE.
  - RELEASE: wait for `i_Tx_Done`=0, then clear `o_Grant`, set the pointer to (k+1) mod NUM_REQ, and go to IDLE.
- `o_Tx_Byte` is stable from capture until the next capture.
- Requester rules:
  - A requester may drop `i_Req_DV` or change its byte on the cycle after the ack is seen.
  - If `i_Req_DV` is still high in the next IDLE, that is a new byte.
  - A `i_Req_DV` that drops before its ack is legal; the byte is simply not sent.
- Simultaneous requests: exactly one ack per transfer.
  - With all requesters continuously valid, grants cycle 0,1,…,N-1,0.
- Reset asserted mid-frame:
  - Outputs go to their reset values immediately and asynchronously.
  - After release, the block stays in SYNC until `uart_tx` completes its frame and its done has fallen.

## Timing
- Request to capture: a request seen at edge t in IDLE gives ack, grant and `o_Tx_DV` high after edge t (cycle t+1). `o_Tx_DV` is low at t+2.
- Ack latency from `i_Req_DV` rising while idle: 1 cycle.
- Transfer: `uart_tx` done rises 10*CLKS_PER_BIT+1 cycles after the DV pulse and stays high 2 cycles.
  - RELEASE exits on the cycle after done falls.
  - IDLE is re-entered about 3 cycles after done first rises.
- Back-to-back throughput: one frame per 10*CLKS_PER_BIT+5 cycles.
- `i_Tx_Active` is used only in SYNC.

## Configuration
- Macro: `UART_ARB_FIXED_PRIO0_EN`.
- Defined: requester 0 wins in IDLE whenever its `i_Req_DV` is high. Requesters 1..N-1 share the remaining grants round-robin among themselves, using the same pointer rule restricted to 1..N-1.
- Not defined: pure round-robin over all NUM_REQ requesters, as described above.

## Test plan
- **Single request.** Reset, then `uart_tx` CLKS_PER_BIT=4 and `i_Req_DV[2]`=1 with byte 8'hA5.
  - Expect `o_Req_Ack[2]` and `o_Tx_DV` high for exactly 1 cycle, one cycle after the request.
  - Expect the serial line to carry 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop).
  - Expect `o_Grant` to return to 0 and `o_Busy` to 0.
- **All requesters continuously valid.** NUM_REQ=4, bytes 8'h10/8'h11/8'h12/8'h13.
  - Expect the serial output sequence 10,11,12,13,10.
  - Expect exactly one ack per frame.
  - Expect no `o_Tx_DV` pulse while `i_Tx_Active`=1.
- **Pointer wrap.** Only requesters 3 and 0 valid, with the pointer at 3.
  - Expect grant order 3,0,3.
  - Expect 3 to be followed by 0, not by a stall.
- **Early withdrawal.** Requester 1 drops `i_Req_DV` in WAIT_DONE of requester 0's frame, before it is served.
  - Expect no ack on 1, no extra frame, and the block to return to IDLE.
- **Reset mid-frame.** Assert `i_Rst_L`=0 for 3 cycles during data bit 4, then release.
  - Expect all outputs at reset values during reset.
  - Expect the block to hold in SYNC (`o_Busy`=1) until the orphaned frame's done falls.
  - Expect a request then served normally.
- **Fixed priority, with `UART_ARB_FIXED_PRIO0_EN` defined.** Requesters 0 and 2 continuously valid.
  - Expect every grant to go to 0.
  - Drop requester 0: expect the next grant to go to 2.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NUM_REQ byte sources.
// Optional UART_ARB_FIXED_PRIO0_EN: requester 0 always wins, others rotate among 1..NUM_REQ-1.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic [NUM_REQ-1:0]   i_Req_DV,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Busy,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done
);

    typedef enum logic [2:0] {
        ST_SYNC      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RELEASE   = 3'd4
    } state_t;

    localparam logic [PTR_W:0]     NREQ_EXT = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(NUM_REQ-1);
    localparam logic [PTR_W-1:0]   PTR_ZERO = PTR_W'(0);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    state_t             state_r;
    logic [PTR_W-1:0]   ptr_r;
    logic [PTR_W-1:0]   grant_idx_r;
    logic [PTR_W:0]     scan_s;
    logic               win_vld_s;
    logic [PTR_W-1:0]   win_idx_s;

`ifdef UART_ARB_FIXED_PRIO0_EN
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   WRAP_SUB = (PTR_W+1)'(NUM_REQ-1);
    logic [PTR_W-1:0]   ptr_eff_s;

    // Winner select: requester 0 first, then rotate over 1..NUM_REQ-1 from the pointer.
    // Scanning from the far end lets the entry nearest the pointer overwrite the rest.
    always_comb begin
        win_vld_s = 1'b0;
        win_idx_s = PTR_ZERO;
        scan_s    = {(PTR_W+1){1'b0}};
        ptr_eff_s = (ptr_r == PTR_ZERO) ? PTR_ONE : ptr_r;
        for (int i = NUM_REQ-2; i >= 0; i--) begin
            scan_s    = {1'b0, ptr_eff_s} + (PTR_W+1)'(i);
            scan_s    = (scan_s >= NREQ_EXT) ? (scan_s - WRAP_SUB) : scan_s;
            win_vld_s = win_vld_s | i_Req_DV[scan_s[PTR_W-1:0]];
            win_idx_s = i_Req_DV[scan_s[PTR_W-1:0]] ? scan_s[PTR_W-1:0] : win_idx_s;
        end
        win_vld_s = win_vld_s | i_Req_DV[0];
        win_idx_s = i_Req_DV[0] ? PTR_ZERO : win_idx_s;
    end
`else
    // Winner select: first valid requester at or after the pointer, modulo NUM_REQ.
    // Scanning from the far end lets the entry nearest the pointer overwrite the rest.
    always_comb begin
        win_vld_s = 1'b0;
        win_idx_s = PTR_ZERO;
        scan_s    = {(PTR_W+1){1'b0}};
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            scan_s    = {1'b0, ptr_r} + (PTR_W+1)'(i);
            scan_s    = (scan_s >= NREQ_EXT) ? (scan_s - NREQ_EXT) : scan_s;
            win_vld_s = win_vld_s | i_Req_DV[scan_s[PTR_W-1:0]];
            win_idx_s = i_Req_DV[scan_s[PTR_W-1:0]] ? scan_s[PTR_W-1:0] : win_idx_s;
        end
    end
`endif

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r     <= ST_SYNC;
            ptr_r       <= PTR_ZERO;
            grant_idx_r <= PTR_ZERO;
            o_Req_Ack   <= {NUM_REQ{1'b0}};
            o_Grant     <= {NUM_REQ{1'b0}};
            o_Busy      <= 1'b1;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= 8'h00;
        end else begin
            case (state_r)
                // uart_tx has no reset: let any orphaned frame finish first.
                ST_SYNC: begin
                    if (!i_Tx_Active && !i_Tx_Done) begin
                        state_r <= ST_IDLE;
                        o_Busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (win_vld_s) begin
                        o_Tx_Byte   <= i_Req_Byte[{win_idx_s, 3'b000} +: 8];
                        o_Grant     <= ONE_HOT0 << win_idx_s;
                        o_Req_Ack   <= ONE_HOT0 << win_idx_s;
                        o_Tx_DV     <= 1'b1;
                        o_Busy      <= 1'b1;
                        grant_idx_r <= win_idx_s;
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    o_Tx_DV   <= 1'b0;
                    o_Req_Ack <= {NUM_REQ{1'b0}};
                    state_r   <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        state_r <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!i_Tx_Done) begin
                        o_Grant <= {NUM_REQ{1'b0}};
                        o_Busy  <= 1'b0;
                        ptr_r   <= (grant_idx_r == PTR_LAST) ? PTR_ZERO : (grant_idx_r + PTR_W'(1));
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_SYNC;
                    o_Req_Ack <= {NUM_REQ{1'b0}};
                    o_Grant   <= {NUM_REQ{1'b0}};
                    o_Busy    <= 1'b1;
                    o_Tx_DV   <= 1'b0;
                end
            endcase
        end
    end

endmodule
